riscv_lsu: RTL and testbench

//   Load/store unit downstream of the riscv core's execute stage: takes one LOAD/STORE

---
 rtl/riscv_lsu_pkg.sv | 28 ++
 rtl/riscv_byte_ram.sv | 22 ++
 rtl/riscv_lsu.sv | 158 +++++++++++++++
 tb/tb_riscv_lsu.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared constants for the riscv load/store unit: configuration defaults and the
// RISC-V funct3 codes for loads and stores, plus a helper for access size.
package riscv_lsu_pkg;

  localparam int          MAX_GPIO      = 7;
  localparam int          WORD          = 32;
  localparam int          LSU_MEM_BYTES = 4096;
  localparam logic [31:0] LSU_GPIO_ADDR = 32'h0000_1000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte count from funct3[1:0]: 00 byte, 01 half, otherwise word.
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/riscv_byte_ram.sv
// Private byte-wide data RAM for the LSU: one synchronous write port, asynchronous
// read, contents are not reset.
module riscv_byte_ram #(
  parameter int MEM_BYTES = 4096,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one request at a time, byte-serial access to the private RAM,
// single-cycle GPIO register access, and checked rejection of malformed requests.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int          MEM_BYTES = LSU_MEM_BYTES,
  parameter logic [31:0] GPIO_ADDR = LSU_GPIO_ADDR,
  parameter int          GPIO_W    = MAX_GPIO + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [GPIO_W-1:0] gpio
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} lsu_state_t;

  lsu_state_t     state, state_next;
  logic           we_q;
  logic [2:0]     f3_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    load_buf;
  logic [31:0]    load_merged;
  logic [1:0]     cnt;
  logic           last;
  logic           accept;

  logic [2:0]     req_n;
  logic [32:0]    req_end;
  logic           f3_ok, align_ok, is_gpio, req_err;

  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [7:0]     ram_wdata, ram_rdata;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (f3)
      F3_LB:   return 32'(b);
      F3_LH:   return 32'(h);
      F3_LBU:  return {24'd0, raw[7:0]};
      F3_LHU:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign req_ready  = (state == ST_IDLE) && !rst;
  assign resp_valid = (state == ST_RESP) && !rst;
  assign accept     = req_valid && req_ready;

  // The 33-bit end address makes a wrap past 2^32 land out of range.
  always_comb begin
    req_n    = access_bytes(req_funct3[1:0]);
    req_end  = {1'b0, req_addr} + 33'(req_n) - 33'd1;
    f3_ok    = req_we ? (req_funct3 inside {F3_SB, F3_SH, F3_SW})
                      : (req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    case (req_funct3[1:0])
      2'b01:   align_ok = !req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    is_gpio  = (req_addr == GPIO_ADDR);
    req_err  = !f3_ok || !align_ok ||
               (is_gpio ? (req_funct3 != F3_LW) : (req_end >= 33'(MEM_BYTES)));
  end

  assign last      = (cnt == 2'(access_bytes(f3_q[1:0]) - 3'd1));
  assign ram_addr  = addr_q + AW'(cnt);
  assign ram_wdata = wdata_q[{cnt, 3'b000} +: 8];
  assign ram_we    = (state == ST_ACCESS) && we_q && !rst;

  always_comb begin
    load_merged = load_buf;
    load_merged[{cnt, 3'b000} +: 8] = ram_rdata;
  end

  riscv_byte_ram #(.MEM_BYTES(MEM_BYTES), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = (req_err || is_gpio) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (last)   state_next = ST_RESP;
      ST_RESP:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // Control and architecturally visible state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      gpio       <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: if (accept) begin
          cnt <= 2'd0;
          if (req_err) begin
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end else if (is_gpio) begin
            resp_err <= 1'b0;
            if (req_we) begin
              gpio       <= req_wdata[GPIO_W-1:0];
              resp_rdata <= 32'd0;
            end else begin
              resp_rdata <= 32'(gpio);
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + 2'd1;
          if (last) begin
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? 32'd0 : load_extend(f3_q, load_merged);
          end
        end
        default: ;
      endcase
    end
  end

  // Request payload and load assembly buffer.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr[AW-1:0];
      wdata_q <= req_wdata;
    end
    if (state == ST_ACCESS) load_buf <= load_merged;
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: a behavioural byte-memory/GPIO model predicts each
// response, which is queued at accept time and compared when resp_valid fires.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  localparam int          GW   = MAX_GPIO + 1;
  localparam logic [31:0] GPIO = LSU_GPIO_ADDR;

  logic          clk, rst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic [GW-1:0] gpio;

  riscv_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .gpio       (gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          delta;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [7:0]    mdl_mem [4096];
  logic [GW-1:0] mdl_gpio;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour; delta is the number of cycles from accept to the response cycle minus one.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd,
                           output logic err, output int delta);
    int     n;
    longint last_b;
    logic   legal, gp;
    n      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal  = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    gp     = (addr == GPIO);
    last_b = longint'({32'd0, addr}) + longint'(n) - 1;
    err    = !legal || (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00) ||
             (gp ? (f3 != 3'd2) : (last_b >= 4096));
    rd     = 32'd0;
    delta  = 0;
    if (err) return;
    if (gp) begin
      if (we) mdl_gpio = wdata[GW-1:0];
      else    rd = 32'(mdl_gpio);
      return;
    end
    delta = n;
    for (int k = 0; k < n; k++) begin
      if (we) mdl_mem[int'(addr) + k] = wdata[8*k +: 8];
      else    rd[8*k +: 8] = mdl_mem[int'(addr) + k];
    end
    if (!we) begin
      case (f3)
        3'd0:    rd = {{24{rd[7]}}, rd[7:0]};
        3'd1:    rd = {{16{rd[15]}}, rd[15:0]};
        default: ;
      endcase
    end
  endtask

  // Drive a request and hold it until accepted; returns with valid still high, one
  // ns into the cycle after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int acc);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check_eq("ready_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic issue_expect(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input string tag);
    exp_t e;
    int   acc;
    issue(we, f3, addr, wdata, acc);
    model_req(we, f3, addr, wdata, e.rdata, e.err, e.delta);
    e.acc_cyc = acc;
    e.tag     = tag;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check_eq("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    issue_expect(we, f3, addr, wdata, tag);
    req_valid = 1'b0;
    wait_drain();
  endtask

  always @(posedge clk) if (req_valid && req_ready) n_acc <= n_acc + 1;

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        check_eq("resp_without_request", {31'd0, resp_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq({mon_e.tag, "_rdata"}, resp_rdata, mon_e.rdata);
        check_eq({mon_e.tag, "_err"}, {31'd0, resp_err}, {31'd0, mon_e.err});
        check_eq({mon_e.tag, "_lat"}, 32'(cyc - mon_e.acc_cyc), 32'(mon_e.delta));
      end
    end
  end

  initial begin
    int a, a2, acc_base;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    mdl_gpio = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_err", {31'd0, resp_err}, 32'd0);
    check_eq("rst_gpio", 32'(gpio), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", {31'd0, req_ready}, 32'd1);

    // Word store/load round trip.
    do_req(1'b1, F3_SW, 32'h100, 32'h1122_3344, "sw_100");
    do_req(1'b0, F3_LW, 32'h100, 32'h0, "lw_100");
    check_eq("lw_100_const", resp_rdata, 32'h1122_3344);

    // Byte/half with sign and zero extension.
    do_req(1'b1, F3_SB,  32'h101, 32'h0000_0080, "sb_101");
    do_req(1'b0, F3_LB,  32'h101, 32'h0, "lb_101");
    check_eq("lb_101_const", resp_rdata, 32'hFFFF_FF80);
    do_req(1'b0, F3_LBU, 32'h101, 32'h0, "lbu_101");
    do_req(1'b0, F3_LH,  32'h102, 32'h0, "lh_102");
    check_eq("lh_102_const", resp_rdata, 32'h0000_1122);

    // Rejected requests leave memory untouched.
    do_req(1'b0, F3_LH,  32'h101, 32'h0, "lh_mis");
    do_req(1'b1, F3_SW,  32'h102, 32'hDEAD_BEEF, "sw_mis");
    do_req(1'b0, F3_LW,  32'hFFE, 32'h0, "lw_ffe");
    do_req(1'b0, 3'b011, 32'h100, 32'h0, "ld_f3_011");
    do_req(1'b0, 3'b110, 32'h100, 32'h0, "ld_f3_110");
    do_req(1'b1, 3'b011, 32'h100, 32'h0, "st_f3_011");
    do_req(1'b0, F3_LW,  32'h100, 32'h0, "lw_100_after_err");
    check_eq("ram_unchanged", resp_rdata, 32'h1122_8044);

    // Top-of-RAM edges and address overflow.
    do_req(1'b1, F3_SB,  32'hFFF, 32'h0000_005A, "sb_fff");
    do_req(1'b0, F3_LBU, 32'hFFF, 32'h0, "lbu_fff");
    do_req(1'b1, F3_SH,  32'hFFE, 32'h0000_BEEF, "sh_ffe");
    do_req(1'b0, F3_LH,  32'hFFE, 32'h0, "lh_ffe");
    do_req(1'b1, F3_SW,  32'hFFC, 32'hCAFE_F00D, "sw_ffc");
    do_req(1'b0, F3_LHU, 32'hFFE, 32'h0, "lhu_ffe");
    do_req(1'b0, F3_LW,  32'hFFFF_FFFC, 32'h0, "lw_wrap");
    do_req(1'b0, F3_LH,  32'hFFFF_FFFE, 32'h0, "lh_wrap");

    // GPIO register.
    issue_expect(1'b1, F3_SW, GPIO, 32'h0000_00A5, "sw_gpio");
    check_eq("gpio_t1", 32'(gpio), 32'h0000_00A5);
    req_valid = 1'b0;
    wait_drain();
    do_req(1'b0, F3_LW, GPIO, 32'h0, "lw_gpio");
    do_req(1'b1, F3_SB, GPIO, 32'h0000_0011, "sb_gpio");
    check_eq("gpio_after_sb", 32'(gpio), 32'h0000_00A5);
    do_req(1'b0, F3_LH, GPIO, 32'h0, "lh_gpio");
    do_req(1'b0, F3_LW, GPIO + 32'd4, 32'h0, "lw_gpio_plus4");

    // Reset aborting a store after two byte cycles.
    do_req(1'b1, F3_SW, 32'h200, 32'hAABB_CCDD, "sw_200");
    issue(1'b1, F3_SW, 32'h200, 32'h1122_3344, a);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_rst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready_after", {31'd0, req_ready}, 32'd1);
    check_eq("abort_gpio", 32'(gpio), 32'd0);
    mdl_mem[32'h200] = 8'h44;
    mdl_mem[32'h201] = 8'h33;
    mdl_gpio = '0;
    repeat (8) @(negedge clk);
    do_req(1'b0, F3_LW, 32'h200, 32'h0, "lw_200_abort");
    check_eq("abort_partial_const", resp_rdata, 32'hAABB_3344);
    do_req(1'b0, F3_LW, GPIO, 32'h0, "lw_gpio_abort");

    // Request held during a busy load; back-to-back accept.
    acc_base = n_acc;
    issue_expect(1'b0, F3_LW, 32'h100, 32'h0, "lw_busy1");
    a = cyc;
    for (int i = 0; i < 4; i++) begin
      req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      @(negedge clk);
      check_eq("busy_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'hFFC; req_wdata = 32'h0;
    @(negedge clk);
    check_eq("resp_cycle_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("post_resp_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    a2 = cyc;
    check_eq("b2b_accept_cycle", 32'(a2 - a), 32'd6);
    begin
      exp_t e2;
      model_req(1'b0, F3_LW, 32'hFFC, 32'h0, e2.rdata, e2.err, e2.delta);
      e2.acc_cyc = a2;
      e2.tag = "lw_busy2";
      sb.push_back(e2);
    end
    req_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check_eq("accept_count", 32'(n_acc - acc_base), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
